// File: rtl/lsq_pkg.sv
// Shared definitions for the load/store queue: op encodings, op-class helpers,
// the head FSM state type and the default uncached IO address.
package lsq_pkg;

  // Memory op encodings shared with the decoder
  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0010;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;

  // Tag value meaning "operand already holds its value"
  localparam int EMPTY_TAG = 0;

  // Default uncached IO address; loads from it wait for ROB commit
  localparam logic [31:0] IO_ADDR_DEFAULT = 32'h30000;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_LOAD_WAIT  = 2'd1,
    ST_STORE_WAIT = 2'd2
  } lsq_state_t;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // 0 = byte, 1 = half, 2 = word
  function automatic logic [1:0] op_size(input logic [3:0] op);
    logic [1:0] sz;
    case (op)
      OP_LB, OP_LBU, OP_SB: sz = 2'd0;
      OP_LH, OP_LHU, OP_SH: sz = 2'd1;
      default:              sz = 2'd2;
    endcase
    return sz;
  endfunction

  // Only sub-word signed loads need the memory side to sign-extend
  function automatic logic op_signed(input logic [3:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

endpackage

// File: rtl/lsq_oldest_pick.sv
// Rotating priority encoder: returns the first set request bit found when
// scanning upward from head, wrapping DEPTH-1 -> 0.
module lsq_oldest_pick #(
  parameter  int DEPTH = 16,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] req,
  input  logic [PW-1:0]    head,
  output logic             found,
  output logic [PW-1:0]    idx
);

  // Scan from head in age order; PW-bit addition gives the wrap for free
  always_comb begin
    found = 1'b0;
    idx   = head;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && req[head + PW'(i)]) begin
        found = 1'b1;
        idx   = head + PW'(i);
      end
    end
  end

endmodule

// File: rtl/lsq_commit.sv
// In-order load/store queue with commit-gated stores and IO loads.
// Entries capture operands from the CDB, compute addresses oldest-first and
// execute strictly from the head through a small request FSM.
module lsq_commit
  import lsq_pkg::*;
#(
  parameter int              DEPTH   = 16,
  parameter int              XLEN    = 32,
  parameter int              TAG_W   = 4,
  parameter int              N_CDB   = 2,
  parameter logic [XLEN-1:0] IO_ADDR = XLEN'(IO_ADDR_DEFAULT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    flush,
  input  logic                    issue_valid,
  output logic                    issue_ready,
  input  logic [3:0]              issue_op,
  input  logic [TAG_W-1:0]        issue_dest,
  input  logic [TAG_W-1:0]        issue_q1,
  input  logic [XLEN-1:0]         issue_v1,
  input  logic [TAG_W-1:0]        issue_q2,
  input  logic [XLEN-1:0]         issue_v2,
  input  logic [XLEN-1:0]         issue_imm,
  input  logic [N_CDB-1:0]        cdb_valid,
  input  logic [N_CDB*TAG_W-1:0]  cdb_tag,
  input  logic [N_CDB*XLEN-1:0]   cdb_data,
  input  logic                    commit_valid,
  input  logic [TAG_W-1:0]        commit_tag,
  output logic                    res_valid,
  output logic [TAG_W-1:0]        res_tag,
  output logic [XLEN-1:0]         res_data,
  output logic                    res_is_store,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [XLEN-1:0]         mem_addr,
  output logic [XLEN-1:0]         mem_wdata,
  output logic [1:0]              mem_size,
  output logic                    mem_signed,
  input  logic                    mem_ack,
  input  logic [XLEN-1:0]         mem_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = TAG_W + XLEN;
  localparam logic [TAG_W-1:0] NO_TAG = TAG_W'(EMPTY_TAG);

  // Entry storage (register-based: every entry snoops the CDB each cycle)
  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] addr_rdy_reg;
  logic [DEPTH-1:0] reported_reg;
  logic [3:0]       op_reg   [DEPTH];
  logic [TAG_W-1:0] dest_reg [DEPTH];
  logic [TAG_W-1:0] q1_reg   [DEPTH];
  logic [XLEN-1:0]  v1_reg   [DEPTH];
  logic [TAG_W-1:0] q2_reg   [DEPTH];
  logic [XLEN-1:0]  v2_reg   [DEPTH];
  logic [XLEN-1:0]  imm_reg  [DEPTH];
  logic [XLEN-1:0]  addr_reg [DEPTH];

  logic [PW-1:0] head_reg, tail_reg;
  logic [CW-1:0] count_reg;
  lsq_state_t    state_reg;
  // store_blk_reg: a committed store survived a flush and is still in flight
  logic          store_blk_reg;
  // drop_ack_reg: a flushed load's ack is still owed by memory
  logic          drop_ack_reg;

  // Returns {tag, value} after resolving a pending tag against the CDB
  function automatic logic [OW-1:0] snoop(input logic [TAG_W-1:0] q,
                                          input logic [XLEN-1:0]  v);
    logic [OW-1:0] r;
    r = {q, v};
    for (int k = 0; k < N_CDB; k++) begin
      if (q != NO_TAG && cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == q)
        r = {NO_TAG, cdb_data[k*XLEN +: XLEN]};
    end
    return r;
  endfunction

  logic [OW-1:0]    op1_snp  [DEPTH];
  logic [OW-1:0]    op2_snp  [DEPTH];
  logic [DEPTH-1:0] agen_req;
  logic [OW-1:0]    iss_op1, iss_op2;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign op1_snp[gi]  = snoop(q1_reg[gi], v1_reg[gi]);
      assign op2_snp[gi]  = snoop(q2_reg[gi], v2_reg[gi]);
      assign agen_req[gi] = valid_reg[gi] && (q1_reg[gi] == NO_TAG) && !addr_rdy_reg[gi];
    end
  endgenerate

  assign iss_op1 = snoop(issue_q1, issue_v1);
  assign iss_op2 = snoop(issue_q2, issue_v2);

  logic          agen_found;
  logic [PW-1:0] agen_idx;

  lsq_oldest_pick #(.DEPTH(DEPTH)) u_pick (
    .req   (agen_req),
    .head  (head_reg),
    .found (agen_found),
    .idx   (agen_idx)
  );

  // Head entry view and FSM decisions
  logic [3:0]       h_op;
  logic [TAG_W-1:0] h_dest;
  logic [XLEN-1:0]  h_addr;
  logic             head_ok, commit_hit;
  logic             start_load, start_store, notify_store;
  logic             accept, retire;

  assign h_op   = op_reg[head_reg];
  assign h_dest = dest_reg[head_reg];
  assign h_addr = addr_reg[head_reg];

  assign head_ok    = valid_reg[head_reg] && (state_reg == ST_IDLE) &&
                      !drop_ack_reg && !flush;
  assign commit_hit = commit_valid && (commit_tag == h_dest);

  assign start_load   = head_ok && op_is_load(h_op) && addr_rdy_reg[head_reg] &&
                        ((h_addr != IO_ADDR) || commit_hit);
  assign notify_store = head_ok && op_is_store(h_op) && addr_rdy_reg[head_reg] &&
                        (q2_reg[head_reg] == NO_TAG) && !reported_reg[head_reg];
  assign start_store  = head_ok && op_is_store(h_op) && reported_reg[head_reg] &&
                        commit_hit;

  assign issue_ready = (count_reg < CW'(DEPTH)) && !store_blk_reg;
  assign accept      = rdy && !flush && issue_valid && issue_ready;
  assign retire      = rdy && mem_ack &&
                       ((state_reg == ST_LOAD_WAIT) ||
                        (state_reg == ST_STORE_WAIT && !store_blk_reg));

  // Entry state: flush clear, CDB capture, address generation, retire, issue
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg    <= '0;
      addr_rdy_reg <= '0;
      reported_reg <= '0;
    end else if (rdy) begin
      if (flush) begin
        valid_reg    <= '0;
        addr_rdy_reg <= '0;
        reported_reg <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (valid_reg[i]) begin
            q1_reg[i] <= op1_snp[i][OW-1:XLEN];
            v1_reg[i] <= op1_snp[i][XLEN-1:0];
            q2_reg[i] <= op2_snp[i][OW-1:XLEN];
            v2_reg[i] <= op2_snp[i][XLEN-1:0];
          end
        end
        if (agen_found) begin
          addr_reg[agen_idx]     <= v1_reg[agen_idx] + imm_reg[agen_idx];
          addr_rdy_reg[agen_idx] <= 1'b1;
        end
        if (notify_store)
          reported_reg[head_reg] <= 1'b1;
        if (retire)
          valid_reg[head_reg] <= 1'b0;
        if (accept) begin
          valid_reg[tail_reg]    <= 1'b1;
          addr_rdy_reg[tail_reg] <= 1'b0;
          reported_reg[tail_reg] <= 1'b0;
          op_reg[tail_reg]       <= issue_op;
          dest_reg[tail_reg]     <= issue_dest;
          q1_reg[tail_reg]       <= iss_op1[OW-1:XLEN];
          v1_reg[tail_reg]       <= iss_op1[XLEN-1:0];
          q2_reg[tail_reg]       <= iss_op2[OW-1:XLEN];
          v2_reg[tail_reg]       <= iss_op2[XLEN-1:0];
          imm_reg[tail_reg]      <= issue_imm;
        end
      end
    end
  end

  // Ring pointers and occupancy count
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (rdy) begin
      if (flush) begin
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
      end else begin
        head_reg  <= head_reg + PW'(retire);
        tail_reg  <= tail_reg + PW'(accept);
        count_reg <= count_reg + CW'(accept) - CW'(retire);
      end
    end
  end

  // Head FSM with registered memory request and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      store_blk_reg <= 1'b0;
      drop_ack_reg  <= 1'b0;
      res_valid     <= 1'b0;
      res_tag       <= '0;
      res_data      <= '0;
      res_is_store  <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_size      <= 2'd0;
      mem_signed    <= 1'b0;
    end else if (rdy) begin
      res_valid    <= 1'b0;
      res_is_store <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (drop_ack_reg && mem_ack)
            drop_ack_reg <= 1'b0;
          if (start_load) begin
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= h_addr;
            mem_size   <= op_size(h_op);
            mem_signed <= op_signed(h_op);
            state_reg  <= ST_LOAD_WAIT;
          end else if (start_store) begin
            mem_req    <= 1'b1;
            mem_we     <= 1'b1;
            mem_addr   <= h_addr;
            mem_wdata  <= v2_reg[head_reg];
            mem_size   <= op_size(h_op);
            mem_signed <= 1'b0;
            state_reg  <= ST_STORE_WAIT;
          end else if (notify_store) begin
            res_valid    <= 1'b1;
            res_tag      <= h_dest;
            res_data     <= '0;
            res_is_store <= 1'b1;
          end
        end
        ST_LOAD_WAIT: begin
          if (flush) begin
            // Abandon the load; an ack not arriving now is still owed
            mem_req      <= 1'b0;
            drop_ack_reg <= !mem_ack;
            state_reg    <= ST_IDLE;
          end else if (mem_ack) begin
            res_valid <= 1'b1;
            res_tag   <= h_dest;
            res_data  <= mem_rdata;
            mem_req   <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        ST_STORE_WAIT: begin
          // A committed store always completes, flush or not
          if (mem_ack) begin
            mem_req       <= 1'b0;
            store_blk_reg <= 1'b0;
            state_reg     <= ST_IDLE;
          end else if (flush) begin
            store_blk_reg <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsq_commit.sv
// Directed bench for lsq_commit: hand-computed vectors for load, store,
// IO load, full/wrap and both flush cases.
module tb_lsq_commit;
  import lsq_pkg::*;

  localparam int DEPTH = 16;
  localparam int XLEN  = 32;
  localparam int TAG_W = 4;
  localparam int N_CDB = 2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   rdy = 1'b1;
  logic                   flush = 1'b0;
  logic                   issue_valid = 1'b0;
  logic                   issue_ready;
  logic [3:0]             issue_op = '0;
  logic [TAG_W-1:0]       issue_dest = '0, issue_q1 = '0, issue_q2 = '0;
  logic [XLEN-1:0]        issue_v1 = '0, issue_v2 = '0, issue_imm = '0;
  logic [N_CDB-1:0]       cdb_valid = '0;
  logic [N_CDB*TAG_W-1:0] cdb_tag = '0;
  logic [N_CDB*XLEN-1:0]  cdb_data = '0;
  logic                   commit_valid = 1'b0;
  logic [TAG_W-1:0]       commit_tag = '0;
  logic                   res_valid, res_is_store;
  logic [TAG_W-1:0]       res_tag;
  logic [XLEN-1:0]        res_data;
  logic                   mem_req, mem_we, mem_signed;
  logic [XLEN-1:0]        mem_addr, mem_wdata;
  logic [1:0]             mem_size;
  logic                   mem_ack = 1'b0;
  logic [XLEN-1:0]        mem_rdata = '0;

  int n_vec = 0;
  int n_bad = 0;

  lsq_commit #(.DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W), .N_CDB(N_CDB)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_dest(issue_dest), .issue_q1(issue_q1), .issue_v1(issue_v1),
    .issue_q2(issue_q2), .issue_v2(issue_v2), .issue_imm(issue_imm),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .commit_valid(commit_valid), .commit_tag(commit_tag),
    .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data),
    .res_is_store(res_is_store), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
    .mem_signed(mem_signed), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input logic [3:0] op, input logic [3:0] dest, input logic [3:0] q1,
                          input logic [31:0] v1, input logic [3:0] q2, input logic [31:0] v2,
                          input logic [31:0] imm);
    check("issue_ready", {31'd0, issue_ready}, 32'd1);
    issue_op = op; issue_dest = dest; issue_q1 = q1; issue_v1 = v1;
    issue_q2 = q2; issue_v2 = v2; issue_imm = imm; issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic wait_req(input int max);
    int n = 0;
    while (!mem_req && n < max) begin tick(); n++; end
    check("req_wait", {31'd0, mem_req}, 32'd1);
  endtask

  task automatic wait_res(input int max);
    int n = 0;
    while (!res_valid && n < max) begin tick(); n++; end
    check("res_wait", {31'd0, res_valid}, 32'd1);
  endtask

  task automatic ack_mem(input logic [31:0] rdata);
    mem_rdata = rdata;
    mem_ack   = 1'b1;
    tick();
    mem_ack   = 1'b0;
  endtask

  task automatic broadcast(input int ch, input logic [3:0] tag, input logic [31:0] data);
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    cdb_valid[ch] = 1'b1;
    cdb_tag[ch*TAG_W +: TAG_W] = tag;
    cdb_data[ch*XLEN +: XLEN] = data;
    tick();
    cdb_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    tick(); tick();
    check("rst_issue_ready", {31'd0, issue_ready}, 32'd1);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_size", {30'd0, mem_size}, 32'd0);
    rst = 1'b0;
    tick();

    // LW tag 3, base 0x100 + 4
    do_issue(OP_LW, 4'd3, 4'd0, 32'h100, 4'd0, 32'd0, 32'd4);
    check("lw_req_c0", {31'd0, mem_req}, 32'd0);
    tick();
    check("lw_req_c1", {31'd0, mem_req}, 32'd0);
    tick();
    check("lw_req_c2", {31'd0, mem_req}, 32'd1);
    check("lw_addr", mem_addr, 32'h104);
    check("lw_we", {31'd0, mem_we}, 32'd0);
    check("lw_size", {30'd0, mem_size}, 32'd2);
    ack_mem(32'hDEADBEEF);
    check("lw_res_valid", {31'd0, res_valid}, 32'd1);
    check("lw_res_tag", {28'd0, res_tag}, 32'd3);
    check("lw_res_data", res_data, 32'hDEADBEEF);
    check("lw_req_drop", {31'd0, mem_req}, 32'd0);
    tick();
    check("lw_res_pulse", {31'd0, res_valid}, 32'd0);

    // SW tag 5, data from CDB channel 1 tag 7
    do_issue(OP_SW, 4'd5, 4'd0, 32'h200, 4'd7, 32'd0, 32'd0);
    broadcast(1, 4'd7, 32'h55);
    wait_res(10);
    check("sw_is_store", {31'd0, res_is_store}, 32'd1);
    check("sw_res_tag", {28'd0, res_tag}, 32'd5);
    check("sw_res_data", res_data, 32'd0);
    commit_valid = 1'b1; commit_tag = 4'd4;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("sw_gate", {31'd0, mem_req}, 32'd0);
    end
    commit_tag = 4'd5;
    tick();
    commit_valid = 1'b0;
    check("sw_req", {31'd0, mem_req}, 32'd1);
    check("sw_we", {31'd0, mem_we}, 32'd1);
    check("sw_wdata", mem_wdata, 32'h55);
    check("sw_addr", mem_addr, 32'h200);
    ack_mem(32'd0);
    check("sw_done_req", {31'd0, mem_req}, 32'd0);
    check("sw_no_res", {31'd0, res_valid}, 32'd0);

    // IO load waits for commit
    do_issue(OP_LW, 4'd6, 4'd0, 32'h30000, 4'd0, 32'd0, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("io_gate", {31'd0, mem_req}, 32'd0);
    end
    commit_valid = 1'b1; commit_tag = 4'd6;
    tick();
    commit_valid = 1'b0;
    check("io_req", {31'd0, mem_req}, 32'd1);
    check("io_addr", mem_addr, 32'h30000);
    check("io_we", {31'd0, mem_we}, 32'd0);
    ack_mem(32'h1234);
    check("io_res_tag", {28'd0, res_tag}, 32'd6);
    check("io_res_data", res_data, 32'h1234);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("io_single", {31'd0, mem_req}, 32'd0);
    end

    // Fill to DEPTH from index 0, retire one, wrap the 17th entry to index 0
    flush = 1'b1; tick(); flush = 1'b0;
    do_issue(OP_LH, 4'd1, 4'd0, 32'h100, 4'd0, 32'd0, 32'd0);
    for (int i = 1; i < DEPTH; i++)
      do_issue(OP_LW, 4'd2, 4'd9, 32'd0, 4'd0, 32'd0, 32'(4 * i));
    check("full_ready", {31'd0, issue_ready}, 32'd0);
    check("full_req", {31'd0, mem_req}, 32'd1);
    check("lh_addr", mem_addr, 32'h100);
    check("lh_size", {30'd0, mem_size}, 32'd1);
    check("lh_signed", {31'd0, mem_signed}, 32'd1);
    ack_mem(32'hFFFF8000);
    check("retire_ready", {31'd0, issue_ready}, 32'd1);
    check("lh_res_data", res_data, 32'hFFFF8000);
    do_issue(OP_LW, 4'd3, 4'd0, 32'h200, 4'd0, 32'd0, 32'd4);
    broadcast(0, 4'd9, 32'h400);
    for (int i = 1; i < DEPTH; i++) begin
      wait_req(20);
      check("wrap_addr", mem_addr, 32'h400 + 32'(4 * i));
      ack_mem(32'(i));
    end
    wait_req(20);
    check("wrap_last", mem_addr, 32'h204);
    ack_mem(32'h77);
    check("wrap_last_tag", {28'd0, res_tag}, 32'd3);

    // Flush in STORE_WAIT with 5 entries queued
    do_issue(OP_SW, 4'd5, 4'd0, 32'h300, 4'd0, 32'hAA, 32'd0);
    wait_res(10);
    check("fs_notice", {31'd0, res_is_store}, 32'd1);
    for (int i = 0; i < 4; i++)
      do_issue(OP_LW, 4'd2, 4'd9, 32'd0, 4'd0, 32'd0, 32'd0);
    commit_valid = 1'b1; commit_tag = 4'd5;
    tick();
    commit_valid = 1'b0;
    check("fs_req", {31'd0, mem_we & mem_req}, 32'd1);
    flush = 1'b1; tick(); flush = 1'b0;
    check("fs_blocked", {31'd0, issue_ready}, 32'd0);
    check("fs_req_held", {31'd0, mem_req}, 32'd1);
    check("fs_addr", mem_addr, 32'h300);
    check("fs_wdata", mem_wdata, 32'hAA);
    tick(); tick();
    check("fs_still_blocked", {31'd0, issue_ready}, 32'd0);
    ack_mem(32'd0);
    check("fs_ack_req", {31'd0, mem_req}, 32'd0);
    check("fs_ack_ready", {31'd0, issue_ready}, 32'd1);
    check("fs_no_res", {31'd0, res_valid}, 32'd0);
    broadcast(0, 4'd9, 32'h800);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("fs_cleared", {31'd0, mem_req}, 32'd0);
    end

    // Flush in LOAD_WAIT, late ack dropped
    do_issue(OP_LW, 4'd4, 4'd0, 32'h500, 4'd0, 32'd0, 32'd0);
    wait_req(10);
    check("fl_addr", mem_addr, 32'h500);
    flush = 1'b1; tick(); flush = 1'b0;
    check("fl_req_drop", {31'd0, mem_req}, 32'd0);
    tick(); tick();
    ack_mem(32'hBAD);
    check("fl_late_ack", {31'd0, res_valid}, 32'd0);
    tick();
    check("fl_late_ack2", {31'd0, res_valid}, 32'd0);
    do_issue(OP_LW, 4'd8, 4'd0, 32'h600, 4'd0, 32'd0, 32'd8);
    wait_req(10);
    check("fl_next_addr", mem_addr, 32'h608);
    ack_mem(32'h600D);
    check("fl_next_valid", {31'd0, res_valid}, 32'd1);
    check("fl_next_tag", {28'd0, res_tag}, 32'd8);
    check("fl_next_data", res_data, 32'h600D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
